// File: rtl/isa_mon_pkg.sv
// Shared types and constants for the ISA compliance pass/fail/timeout monitor.
package isa_mon_pkg;

    typedef enum logic [1:0] {
        MON_RUN  = 2'd0,
        MON_PASS = 2'd1,
        MON_FAIL = 2'd2,
        MON_TMO  = 2'd3
    } mon_state_e;

    localparam int HOLD_CYCLES_DEF = 4;

    // riscv-tests write 1 to tohost on success; (n << 1) | 1 on failure of test n.
    localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/isa_test_monitor_if.sv
// IF/ID PC sample stream (plus the store port when ISA_MON_TOHOST_EN is defined).
interface isa_test_monitor_if #(
    parameter int PC_W = 32
) ();

    logic            pc_valid;
    logic [PC_W-1:0] pc;
`ifdef ISA_MON_TOHOST_EN
    logic            st_valid;
    logic [PC_W-1:0] st_addr;
    logic [31:0]     st_data;
`endif

`ifdef ISA_MON_TOHOST_EN
    modport master (output pc_valid, pc, st_valid, st_addr, st_data);
    modport slave  (input  pc_valid, pc, st_valid, st_addr, st_data);
`else
    modport master (output pc_valid, pc);
    modport slave  (input  pc_valid, pc);
`endif

endinterface

// File: rtl/isa_mon_loop_det.sv
// Self-loop detector: remembers the last valid PC and counts consecutive repeats.
module isa_mon_loop_det #(
    parameter int PC_W        = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            pc_valid,
    input  logic [PC_W-1:0] pc,
    output logic            parked,
    output logic [PC_W-1:0] last_pc
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);

    logic [7:0] hold;

    function automatic logic [7:0] hold_sat_inc(input logic [7:0] v);
        return (v == HOLD_MAX) ? v : v + 8'd1;
    endfunction

    // Invalid samples (stalls, bubbles) leave the match state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= 8'd0;
            last_pc <= '0;
        end else if (clr) begin
            hold    <= 8'd0;
            last_pc <= '0;
        end else if (pc_valid) begin
            hold    <= (pc == last_pc) ? hold_sat_inc(hold) : 8'd1;
            last_pc <= pc;
        end
    end

    assign parked = (hold == HOLD_MAX);

endmodule

// File: rtl/isa_test_monitor.sv
// Pass/fail/timeout monitor for ISA compliance runs. Optional tohost store
// detection is enabled by defining ISA_MON_TOHOST_EN.
module isa_test_monitor
    import isa_mon_pkg::*;
#(
    parameter int PC_W           = 32,
    parameter int CNT_W          = 32,
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
`ifdef ISA_MON_TOHOST_EN
    parameter logic [31:0] TOHOST_PASS_CODE = TOHOST_PASS,
`endif
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    isa_test_monitor_if.slave mon,
    input  logic [PC_W-1:0]  cfg_pass_pc,
    input  logic [PC_W-1:0]  cfg_fail_pc,
`ifdef ISA_MON_TOHOST_EN
    input  logic [PC_W-1:0]  cfg_tohost,
    output logic [30:0]      tohost_code,
`endif
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] end_cycle,
    output logic [PC_W-1:0]  end_pc,
    output logic [CNT_W-1:0] cycle_count
);

    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e      state, state_nx;
    logic            parked;
    logic [PC_W-1:0] last_pc;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    isa_mon_loop_det #(
        .PC_W        (PC_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_loop_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .pc_valid (mon.pc_valid),
        .pc       (mon.pc),
        .parked   (parked),
        .last_pc  (last_pc)
    );

`ifdef ISA_MON_TOHOST_EN
    logic st_hit;
    assign st_hit = mon.st_valid && (mon.st_addr == cfg_tohost) && mon.st_data[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MON_RUN;
        else        state <= state_nx;
    end

    // Finish priority: tohost store, then fail loop, then pass loop, then watchdog.
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = MON_RUN;
        end else if (state == MON_RUN) begin
`ifdef ISA_MON_TOHOST_EN
            if (st_hit)
                state_nx = (mon.st_data == TOHOST_PASS_CODE) ? MON_PASS : MON_FAIL;
            else
`endif
            if (parked && (last_pc == cfg_fail_pc))
                state_nx = MON_FAIL;
            else if (parked && (last_pc == cfg_pass_pc))
                state_nx = MON_PASS;
            else if (TMO_EN && (cycle_count == TMO_LAST))
                state_nx = MON_TMO;
        end
    end

    always_comb begin
        done    = (state != MON_RUN);
        pass    = (state == MON_PASS);
        fail    = (state == MON_FAIL);
        timeout = (state == MON_TMO);
    end

    // The counter stops on the finishing edge so end_cycle equals the frozen count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            end_cycle   <= '0;
            end_pc      <= '0;
`ifdef ISA_MON_TOHOST_EN
            tohost_code <= '0;
`endif
        end else if (clr) begin
            cycle_count <= '0;
            end_cycle   <= '0;
            end_pc      <= '0;
`ifdef ISA_MON_TOHOST_EN
            tohost_code <= '0;
`endif
        end else if (state == MON_RUN) begin
            if (state_nx == MON_RUN) begin
                cycle_count <= cnt_sat_inc(cycle_count);
            end else begin
                end_cycle <= cycle_count;
                end_pc    <= last_pc;
`ifdef ISA_MON_TOHOST_EN
                if (st_hit && (state_nx == MON_FAIL))
                    tohost_code <= mon.st_data[31:1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_isa_test_monitor.sv
// Directed scoreboard bench for isa_test_monitor (HOLD_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_isa_test_monitor;

    localparam int HOLD = 4;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] cfg_pass_pc;
    logic [31:0] cfg_fail_pc;
    logic        done, pass, fail, timeout;
    logic [31:0] end_cycle, end_pc, cycle_count;
`ifdef ISA_MON_TOHOST_EN
    logic [31:0] cfg_tohost;
    logic [30:0] tohost_code;
`endif

    isa_test_monitor_if #(.PC_W(32)) mon ();

    isa_test_monitor #(
        .PC_W           (32),
        .CNT_W          (32),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .mon         (mon),
        .cfg_pass_pc (cfg_pass_pc),
        .cfg_fail_pc (cfg_fail_pc),
`ifdef ISA_MON_TOHOST_EN
        .cfg_tohost  (cfg_tohost),
        .tohost_code (tohost_code),
`endif
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .end_cycle   (end_cycle),
        .end_pc      (end_pc),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        p, f, t;
        logic [31:0] ec, ep;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        cyc = 0;
    endtask

    task automatic sample(input logic [31:0] p);
        mon.pc_valid = 1'b1;
        mon.pc       = p;
        step();
        mon.pc_valid = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic p, input logic f, input logic t,
                            input logic [31:0] ec, input logic [31:0] ep);
        exp_t e;
        e.tag = tag; e.p = p; e.f = f; e.t = t; e.ec = ec; e.ep = ep;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int budget);
        exp_t e;
        int   k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        e = sb.pop_front();
        check({e.tag, "_done"},      done,        1);
        check({e.tag, "_pass"},      pass,        e.p);
        check({e.tag, "_fail"},      fail,        e.f);
        check({e.tag, "_timeout"},   timeout,     e.t);
        check({e.tag, "_end_cycle"}, end_cycle,   e.ec);
        check({e.tag, "_end_pc"},    end_pc,      e.ep);
        check({e.tag, "_frozen"},    cycle_count, e.ec);
    endtask

`ifdef ISA_MON_TOHOST_EN
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mon.st_valid = 1'b1;
        mon.st_addr  = a;
        mon.st_data  = d;
        step();
        mon.st_valid = 1'b0;
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        mon.pc_valid = 1'b0;
        mon.pc       = '0;
        cfg_pass_pc  = 32'h5f0;
        cfg_fail_pc  = 32'h5dc;
`ifdef ISA_MON_TOHOST_EN
        mon.st_valid = 1'b0;
        mon.st_addr  = '0;
        mon.st_data  = '0;
        cfg_tohost   = 32'h1000;
`endif
        #12;
        check("rst_done",        done,        0);
        check("rst_flags",       {pass, fail, timeout}, 0);
        check("rst_end_cycle",   end_cycle,   0);
        check("rst_end_pc",      end_pc,      0);
        check("rst_cycle_count", cycle_count, 0);
        rst_n = 1'b1;

        // Pass loop after some ordinary fetches
        do_clr();
        sample(32'h100);
        sample(32'h104);
        for (int i = 0; i < HOLD; i++) sample(32'h5f0);
        push_exp("pass", 1, 0, 0, cyc, 32'h5f0);
        check("pass_latency", done, 0);
        pop_check(1);

        // Fail loop with stalls between matching samples
        do_clr();
        check("clr_done", done, 0);
        sample(32'h5dc); idle(1);
        sample(32'h5dc); idle(1);
        sample(32'h5dc); idle(2);
        check("stall_no_finish", done, 0);
        sample(32'h5dc);
        push_exp("fail_stall", 0, 1, 0, cyc, 32'h5dc);
        check("fail_latency", done, 0);
        pop_check(1);

        // A different PC breaks the run; hold restarts at 1
        do_clr();
        for (int i = 0; i < 3; i++) sample(32'h5f0);
        sample(32'h5f4);
        for (int i = 0; i < 3; i++) sample(32'h5f0);
        idle(2);
        check("break_no_finish", done, 0);
        check("break_counting",  cycle_count, cyc);
        sample(32'h5f0);
        push_exp("pass_restart", 1, 0, 0, cyc, 32'h5f0);
        pop_check(1);

        // Watchdog with a toggling PC
        do_clr();
        push_exp("tmo", 0, 0, 1, TMO - 1, ((TMO - 1) % 2 == 1) ? 32'h200 : 32'h204);
        for (int i = 1; i <= TMO + 5 && !done; i++) sample((i % 2 == 1) ? 32'h200 : 32'h204);
        check("tmo_edge", cyc, TMO);
        pop_check(0);
        idle(3);
        check("tmo_still_frozen", cycle_count, TMO - 1);
        do_clr();
        check("tmo_clr_flags", {done, pass, fail, timeout}, 0);
        check("tmo_clr_end_cycle", end_cycle, 0);
        check("tmo_clr_end_pc", end_pc, 0);
        check("tmo_clr_count", cycle_count, 0);
        idle(3);
        check("tmo_clr_restart", cycle_count, 3);

        // Same pass and fail address: fail wins
        cfg_pass_pc = 32'h300;
        cfg_fail_pc = 32'h300;
        do_clr();
        for (int i = 0; i < HOLD; i++) sample(32'h300);
        push_exp("same_pc", 0, 1, 0, cyc, 32'h300);
        pop_check(1);

        // Asynchronous reset from a terminal state, away from any edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags",     {done, pass, fail, timeout}, 0);
        check("arst_end_cycle", end_cycle, 0);
        check("arst_end_pc",    end_pc, 0);
        check("arst_count",     cycle_count, 0);
        #1 rst_n = 1'b1;
        cfg_pass_pc = 32'h5f0;
        cfg_fail_pc = 32'h5dc;
        cyc = 0;

        // Asynchronous reset mid-hold discards the partial match
        for (int i = 0; i < HOLD - 1; i++) sample(32'h5f0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_count", cycle_count, 0);
        #1 rst_n = 1'b1;
        cyc = 0;
        sample(32'h5f0);
        idle(1);
        check("arst_hold_cleared", done, 0);
        for (int i = 0; i < HOLD - 1; i++) sample(32'h5f0);
        push_exp("pass_after_arst", 1, 0, 0, cyc, 32'h5f0);
        pop_check(1);

`ifdef ISA_MON_TOHOST_EN
        do_clr();
        store(32'h1000, 32'h7);
        push_exp("tohost_fail", 0, 1, 0, cyc - 1, 32'h0);
        pop_check(0);
        check("tohost_code_fail", tohost_code, 3);
        do_clr();
        check("tohost_code_clr", tohost_code, 0);
        store(32'h1000, 32'h1);
        push_exp("tohost_pass", 1, 0, 0, cyc - 1, 32'h0);
        pop_check(0);
        check("tohost_code_pass", tohost_code, 0);
        do_clr();
        store(32'h1000, 32'h2);
        idle(1);
        check("tohost_even_ignored", done, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/isa_test_monitor.md
Name: isa_test_monitor

Overview:
- Synthesizable pass/fail/timeout monitor for ISA compliance runs on the NF5 core.
- Watches the IF/ID PC stream and detects when the core parks in the pass or fail self-loop.
- Adds a watchdog timeout and captures the end cycle and end PC.
- Instantiated beside Core in benches and FPGA test wrappers; pass/fail addresses are runtime inputs, so no recompile is needed per test.

Parameters:
- PC_W, 32, PC/address width.
- CNT_W, 32, cycle counter width.
- HOLD_CYCLES, 4, consecutive valid matching PC samples that count as "parked"; legal range 1..255.
- TIMEOUT_CYCLES, 100000, watchdog limit; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous restart: return to RUN and zero all counters
- pc_valid  in  1  pc is a real IF/ID sample this cycle (low on stall or bubble)
- pc  in  PC_W  IF/ID current PC
- cfg_pass_pc  in  PC_W  address of the pass loop
- cfg_fail_pc  in  PC_W  address of the fail loop
- done  out  1  test finished (sticky)
- pass  out  1  finished by pass
- fail  out  1  finished by fail
- timeout  out  1  finished by watchdog
- end_cycle  out  CNT_W  cycle_count value at finish
- end_pc  out  PC_W  last valid pc sampled at finish
- cycle_count  out  CNT_W  free-running count of cycles spent in RUN

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state RUN; hold counter 0; last_pc 0.
- States:
  - RUN: active monitoring.
  - PASS, FAIL, TMO: terminal and sticky. Only rst_n or clr leaves them.
- cycle_count:
  - Increments every cycle in RUN.
  - Saturates at all-ones; it never wraps.
  - Frozen in terminal states.
- Hold counter, updated only when pc_valid=1:
  - If pc equals last_pc, increment, saturating at HOLD_CYCLES.
  - Otherwise load 1.
  - last_pc takes pc.
  - pc_valid=0 leaves both unchanged, so stalls neither break nor advance a match.
- Finish detection is evaluated on the registered hold counter and last_pc.
  - Park condition: hold counter = HOLD_CYCLES.
  - Parked with last_pc = cfg_fail_pc → go to FAIL.
  - Otherwise parked with last_pc = cfg_pass_pc → go to PASS.
  - If cfg_pass_pc = cfg_fail_pc, fail has priority.
- Latency: the flag asserts exactly 1 cycle after the clock edge that registers the HOLD_CYCLES-th consecutive matching valid sample.
- Watchdog: in RUN with TIMEOUT_CYCLES≠0, reaching cycle_count = TIMEOUT_CYCLES-1 moves the block to TMO on the next edge. If a pass/fail finish lands on the same edge, pass/fail wins.
- On entering any terminal state, one edge does all of the following:
  - done=1 and the matching flag =1; exactly one of pass, fail, timeout is ever high.
  - end_cycle ← cycle_count.
  - end_pc ← last_pc.
- clr:
  - Has priority over every transition in the same cycle.
  - Clears all outputs and counters and sets last_pc to 0.
  - The first valid sample after clr loads hold = 1.
- rst_n asserted mid-run: immediate asynchronous clear to the reset values.
- Comparisons are full PC_W equality; there are no range or ">=" comparisons.

Optional Feature:
- Macro: ISA_MON_TOHOST_EN.
- When defined, extra ports and a parameter exist:
  - st_valid in 1, st_addr in PC_W, st_data in 32, cfg_tohost in PC_W.
  - Output tohost_code out 31.
  - A store with st_valid=1, st_addr=cfg_tohost and st_data[0]=1 finishes the test on the next edge.
  - st_data=1 → PASS. Any other odd value → FAIL, with tohost_code ← st_data[31:1] (the failing test number).
  - A tohost finish has priority over a PC-loop finish and over timeout in the same cycle.
  - Even st_data is ignored.
  - tohost_code resets to 0 and is cleared by clr.
- When undefined: the ports are absent and only PC-loop and timeout detection exist.

Decomposition:
- Package isa_mon_pkg holds:
  - The state enum mon_state_e {MON_RUN, MON_PASS, MON_FAIL, MON_TMO}.
  - A default HOLD_CYCLES constant.
  - The riscv-tests pass code constant TOHOST_PASS = 1.
- One natural sub-module, isa_mon_loop_det: the last_pc register plus the saturating hold counter, with output parked and the registered last_pc.

Test Plan:
- HOLD=4, pass=0x5f0, fail=0x5dc. PC sequence 0x100, 0x104, then 0x5f0 valid ×4 → pass=1, done=1 one cycle after the 4th sample; end_pc=0x5f0; fail=timeout=0.
- Same config, PC at 0x5dc ×3 valid with pc_valid=0 stalls between samples, then a 4th valid 0x5dc → fail=1; the stalls do not reset the match.
- PC 0x5f0 ×3 then 0x5f4 then 0x5f0 ×3 → no finish; hold restarts at 1. One more 0x5f0 → pass.
- TIMEOUT=50, PC toggling 0x200/0x204 → timeout=1 with end_cycle=49, cycle_count frozen at 49. Apply clr → all outputs 0 and cycle_count restarts from 0.
- pass_pc=fail_pc=0x300, PC 0x300 ×4 → fail=1 (fail priority). Assert rst_n=0 mid-hold → all outputs 0 immediately.
- ISA_MON_TOHOST_EN: tohost=0x1000.
  - Store data 0x7 → fail=1, tohost_code=3.
  - After clr, store data 0x1 → pass=1.
  - Store data 0x2 → ignored.
